// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding, length codes and I/O decode for mem_ctrl
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  // addr[17:16] value that selects the memory-mapped I/O space
  localparam logic [1:0] IO_SPACE = 2'b11;

  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
  } req_t;

  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_BYTE, LEN_HALF: return len;
      default:            return LEN_WORD;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] space);
    return space == IO_SPACE;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - one-deep pending-request latch with same-cycle bypass
module mem_req_slot
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        en_i,
  input  logic        is_write_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] data_i,
  input  logic        take_i,
  output logic        valid_o,
  output logic        is_write_o,
  output logic [31:0] addr_o,
  output logic [2:0]  len_o,
  output logic [31:0] data_o
);

  logic valid_q, valid_d;
  req_t slot_q, slot_d, in_req, view;

  assign in_req = '{is_write: is_write_i, addr: addr_i, len: norm_len(len_i), data: data_i};

  // An empty slot exposes the incoming pulse directly so IDLE can start it this cycle
  assign valid_o    = valid_q | (rdy & en_i);
  assign view       = valid_q ? slot_q : in_req;
  assign is_write_o = view.is_write;
  assign addr_o     = view.addr;
  assign len_o      = view.len;
  assign data_o     = view.data;

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (rdy) begin
      if (valid_q) begin
        if (take_i) valid_d = 1'b0;
      end else if (en_i && !take_i) begin
        valid_d = 1'b1;
        slot_d  = in_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller arbitrating load/store and fetch ports
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        lsb_enable,
  input  logic        lsb_is_write,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_data_len,
  input  logic [31:0] lsb_write_data,
  output logic        lsb_data_valid,
  output logic [31:0] lsb_data,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_data_valid,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  logic        lsb_pend, lsb_p_wr, if_pend, if_p_wr;
  logic [31:0] lsb_p_addr, lsb_p_data, if_p_addr, if_p_data;
  logic [2:0]  lsb_p_len, if_p_len;
  logic        take_lsb, take_if;

  mem_req_slot u_lsb_slot (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .en_i       (lsb_enable),
    .is_write_i (lsb_is_write),
    .addr_i     (lsb_addr),
    .len_i      (lsb_data_len),
    .data_i     (lsb_write_data),
    .take_i     (take_lsb),
    .valid_o    (lsb_pend),
    .is_write_o (lsb_p_wr),
    .addr_o     (lsb_p_addr),
    .len_o      (lsb_p_len),
    .data_o     (lsb_p_data)
  );

  mem_req_slot u_if_slot (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .en_i       (if_enable),
    .is_write_i (1'b0),
    .addr_i     (if_addr),
    .len_i      (LEN_WORD),
    .data_i     (32'd0),
    .take_i     (take_if),
    .valid_o    (if_pend),
    .is_write_o (if_p_wr),
    .addr_o     (if_p_addr),
    .len_o      (if_p_len),
    .data_o     (if_p_data)
  );

  logic        sel_wr;
  logic [31:0] sel_addr, sel_data;
  logic [2:0]  sel_len;

  assign sel_wr   = lsb_pend ? lsb_p_wr   : if_p_wr;
  assign sel_addr = lsb_pend ? lsb_p_addr : if_p_addr;
  assign sel_data = lsb_pend ? lsb_p_data : if_p_data;
  assign sel_len  = lsb_pend ? lsb_p_len  : if_p_len;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, len_q, len_d, nxt;
  logic [1:0]  lane;
  logic        port_lsb_q, port_lsb_d;
  logic [31:0] base_q, base_d, wdata_q, wdata_d;
  logic [31:0] mem_a_q, mem_a_d, prev_a_q, prev_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [31:0] buf_q, buf_d;
  logic        lsb_valid_q, lsb_valid_d, if_valid_q, if_valid_d;
  logic [31:0] lsb_data_q, lsb_data_d, if_data_q, if_data_d;
  logic        stall;

  assign stall = is_io(mem_a_q[17:16]) && io_buffer_full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    port_lsb_d  = port_lsb_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    mem_a_d     = mem_a_q;
    prev_a_d    = prev_a_q;
    mem_dout_d  = mem_dout_q;
    buf_d       = buf_q;
    lsb_valid_d = lsb_valid_q;
    if_valid_d  = if_valid_q;
    lsb_data_d  = lsb_data_q;
    if_data_d   = if_data_q;
    take_lsb    = 1'b0;
    take_if     = 1'b0;
    nxt         = cnt_q + 3'd1;
    lane        = cnt_q[1:0] - 2'd1;
    if (rdy) begin
      lsb_valid_d = 1'b0;
      if_valid_d  = 1'b0;
      prev_a_d    = mem_a_q;
      case (state_q)
        ST_IDLE: begin
          if (lsb_pend || if_pend) begin
            take_lsb   = lsb_pend;
            take_if    = !lsb_pend;
            state_d    = sel_wr ? ST_WRITE : ST_READ;
            cnt_d      = 3'd0;
            len_d      = sel_len;
            port_lsb_d = lsb_pend;
            base_d     = sel_addr;
            wdata_d    = sel_data;
            mem_a_d    = sel_addr;
            mem_dout_d = sel_data[7:0];
            buf_d      = '0;
          end
        end
        ST_READ: begin
          // mem_din now carries the byte addressed in the previous cycle
          if (cnt_q != 3'd0) buf_d[{lane, 3'b000} +: 8] = mem_din;
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            if (port_lsb_q) begin
              lsb_valid_d = 1'b1;
              lsb_data_d  = buf_d;
            end else begin
              if_valid_d = 1'b1;
              if_data_d  = buf_d;
            end
          end else begin
            if (nxt < len_q) mem_a_d = base_q + {29'd0, nxt};
            cnt_d = nxt;
          end
        end
        ST_WRITE: begin
          if (!stall) begin
            if (cnt_q == len_q - 3'd1) begin
              state_d     = ST_IDLE;
              lsb_valid_d = 1'b1;
            end else begin
              cnt_d      = nxt;
              mem_a_d    = base_q + {29'd0, nxt};
              mem_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      port_lsb_q  <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      mem_a_q     <= '0;
      prev_a_q    <= '0;
      mem_dout_q  <= '0;
      buf_q       <= '0;
      lsb_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      lsb_data_q  <= '0;
      if_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      port_lsb_q  <= port_lsb_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      mem_a_q     <= mem_a_d;
      prev_a_q    <= prev_a_d;
      mem_dout_q  <= mem_dout_d;
      buf_q       <= buf_d;
      lsb_valid_q <= lsb_valid_d;
      if_valid_q  <= if_valid_d;
      lsb_data_q  <= lsb_data_d;
      if_data_q   <= if_data_d;
    end
  end

  // While frozen, replay the last active address so the RAM re-presents the
  // byte that the in-flight read still has to capture when rdy returns.
  assign mem_a          = rdy ? mem_a_q : prev_a_q;
  assign mem_dout       = mem_dout_q;
  assign mem_wr         = !rst && rdy && (state_q == ST_WRITE) && !stall;
  assign lsb_data_valid = lsb_valid_q & rdy;
  assign if_data_valid  = if_valid_q & rdy;
  assign lsb_data       = lsb_data_q;
  assign if_data        = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        lsb_enable, lsb_is_write;
  logic [31:0] lsb_addr, lsb_write_data;
  logic [2:0]  lsb_data_len;
  logic        lsb_data_valid;
  logic [31:0] lsb_data;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        if_data_valid;
  logic [31:0] if_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        tb_init;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
    bit          chk_data;
  } rd_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          at;
  } wr_exp_t;

  rd_exp_t lsb_q[$];
  rd_exp_t if_q[$];
  wr_exp_t wr_q[$];

  logic [7:0] ram [0:1023];

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .lsb_enable     (lsb_enable),
    .lsb_is_write   (lsb_is_write),
    .lsb_addr       (lsb_addr),
    .lsb_data_len   (lsb_data_len),
    .lsb_write_data (lsb_write_data),
    .lsb_data_valid (lsb_data_valid),
    .lsb_data       (lsb_data),
    .if_enable      (if_enable),
    .if_addr        (if_addr),
    .if_data_valid  (if_data_valid),
    .if_data        (if_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: one-cycle read latency, I/O-space writes go to the device, not RAM
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h11;
      ram[10'h101] <= 8'h22;
      ram[10'h102] <= 8'h33;
      ram[10'h103] <= 8'h44;
      ram[10'h202] <= 8'h5A;
      ram[10'h3FF] <= 8'h12;
      ram[10'h000] <= 8'h34;
    end else if (mem_wr && mem_a[17:16] != 2'b11) begin
      ram[mem_a[9:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a completion or a write
  always @(negedge clk) begin
    rd_exp_t r;
    wr_exp_t w;
    if (lsb_data_valid) begin
      if (lsb_q.size() == 0) chk("lsb_unexpected_valid", 32'd1, 32'd0);
      else begin
        r = lsb_q.pop_front();
        chk("lsb_valid_cycle", cyc, r.at);
        if (r.chk_data) chk("lsb_data", lsb_data, r.data);
      end
    end
    if (if_data_valid) begin
      if (if_q.size() == 0) chk("if_unexpected_valid", 32'd1, 32'd0);
      else begin
        r = if_q.pop_front();
        chk("if_valid_cycle", cyc, r.at);
        chk("if_data", if_data, r.data);
      end
    end
    if (mem_wr) begin
      if (wr_q.size() == 0) chk("unexpected_write", mem_a, 32'hFFFF_FFFF);
      else begin
        w = wr_q.pop_front();
        chk("wr_cycle", cyc, w.at);
        chk("wr_addr", mem_a, w.addr);
        chk("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
      end
    end
  end

  task automatic lsb_pulse(input logic w, input logic [31:0] a, input logic [2:0] len,
                           input logic [31:0] d, output int t);
    @(posedge clk); #1;
    lsb_enable = 1'b1; lsb_is_write = w; lsb_addr = a; lsb_data_len = len; lsb_write_data = d;
    t = cyc;
    @(posedge clk); #1;
    lsb_enable = 1'b0;
  endtask

  task automatic push_lsb(input logic [31:0] d, input int at, input bit cd);
    rd_exp_t e;
    e.data = d; e.at = at; e.chk_data = cd;
    lsb_q.push_back(e);
  endtask

  task automatic push_if(input logic [31:0] d, input int at);
    rd_exp_t e;
    e.data = d; e.at = at; e.chk_data = 1'b1;
    if_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int at);
    wr_exp_t e;
    e.addr = a; e.data = d; e.at = at;
    wr_q.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((lsb_q.size() != 0 || if_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout pending lsb=%0d if=%0d wr=%0d want 0", nm,
               lsb_q.size(), if_q.size(), wr_q.size());
      lsb_q.delete(); if_q.delete(); wr_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; tb_init = 1'b1; rdy = 1'b1;
    lsb_enable = 1'b0; lsb_is_write = 1'b0; lsb_addr = '0; lsb_data_len = 3'd0;
    lsb_write_data = '0; if_enable = 1'b0; if_addr = '0; io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; tb_init = 1'b0;
    @(posedge clk); #1;
    chk("rst_lsb_valid", {31'd0, lsb_data_valid}, 32'd0);
    chk("rst_if_valid",  {31'd0, if_data_valid}, 32'd0);
    chk("rst_lsb_data",  lsb_data, 32'd0);
    chk("rst_if_data",   if_data, 32'd0);
    chk("rst_mem_a",     mem_a, 32'd0);
    chk("rst_mem_dout",  {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr",    {31'd0, mem_wr}, 32'd0);

    // LW 0x100: S = T+1, N = 4, valid at T+6
    lsb_pulse(1'b0, 32'h100, 3'b100, 32'd0, t);
    push_lsb(32'h4433_2211, t + 6, 1'b1);
    drain("lw_100");

    // SH 0x200: two consecutive writes, valid after the second
    lsb_pulse(1'b1, 32'h200, 3'b010, 32'hDEAD_BEEF, t);
    push_wr(32'h200, 8'hEF, t + 1);
    push_wr(32'h201, 8'hBE, t + 2);
    push_lsb(32'd0, t + 3, 1'b0);
    drain("sh_200");
    chk("ram_202_untouched", {24'd0, ram[10'h202]}, 32'h5A);

    lsb_pulse(1'b0, 32'h201, 3'b001, 32'd0, t);
    push_lsb(32'h0000_00BE, t + 3, 1'b1);
    drain("lb_201");

    lsb_pulse(1'b0, 32'h200, 3'b010, 32'd0, t);
    push_lsb(32'h0000_BEEF, t + 4, 1'b1);
    drain("lh_200");

    // Illegal length is a word
    lsb_pulse(1'b0, 32'h100, 3'b011, 32'd0, t);
    push_lsb(32'h4433_2211, t + 6, 1'b1);
    drain("len_illegal");

    // Address wrap 0xFFFFFFFF -> 0x0
    lsb_pulse(1'b0, 32'hFFFF_FFFF, 3'b010, 32'd0, t);
    push_lsb(32'h0000_3412, t + 4, 1'b1);
    drain("wrap");

    // Simultaneous requests: LSB first, IF starts the cycle after LSB valid
    @(posedge clk); #1;
    lsb_enable = 1'b1; lsb_is_write = 1'b0; lsb_addr = 32'h100; lsb_data_len = 3'b100;
    if_enable = 1'b1; if_addr = 32'h100;
    t = cyc;
    @(posedge clk); #1;
    lsb_enable = 1'b0; if_enable = 1'b0;
    push_lsb(32'h4433_2211, t + 6, 1'b1);
    push_if(32'h4433_2211, t + 12);
    drain("arbitration");

    // Fetch alone sees the stored halfword
    @(posedge clk); #1;
    if_enable = 1'b1; if_addr = 32'h200;
    t = cyc;
    @(posedge clk); #1;
    if_enable = 1'b0;
    push_if(32'h005A_BEEF, t + 6);
    drain("if_200");

    // Occupied slot: third pulse is dropped
    @(posedge clk); #1;
    lsb_enable = 1'b1; lsb_is_write = 1'b0; lsb_addr = 32'h100; lsb_data_len = 3'b100;
    t = cyc;
    @(posedge clk); #1;
    lsb_addr = 32'h201; lsb_data_len = 3'b001;
    @(posedge clk); #1;
    lsb_addr = 32'h200; lsb_data_len = 3'b001;
    @(posedge clk); #1;
    lsb_enable = 1'b0;
    push_lsb(32'h4433_2211, t + 6, 1'b1);
    push_lsb(32'h0000_00BE, t + 9, 1'b1);
    drain("slot_occupied");

    // SB to I/O space with the buffer full for three cycles
    @(posedge clk); #1;
    io_buffer_full = 1'b1;
    lsb_enable = 1'b1; lsb_is_write = 1'b1; lsb_addr = 32'h0003_0000; lsb_data_len = 3'b001;
    lsb_write_data = 32'h0000_0077;
    t = cyc;
    push_wr(32'h0003_0000, 8'h77, t + 4);
    push_lsb(32'd0, t + 5, 1'b0);
    @(posedge clk); #1;
    lsb_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    io_buffer_full = 1'b0;
    drain("io_stall");

    // rdy low for two cycles mid-LW delays completion by exactly two
    lsb_pulse(1'b0, 32'h100, 3'b100, 32'd0, t);
    push_lsb(32'h4433_2211, t + 8, 1'b1);
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rdy = 1'b1;
    drain("rdy_freeze");

    // rst mid-LW aborts with no completion
    lsb_pulse(1'b0, 32'h100, 3'b100, 32'd0, t);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_lsb_data", lsb_data, 32'd0);
    chk("abort_if_data",  if_data, 32'd0);
    chk("abort_mem_a",    mem_a, 32'd0);
    chk("abort_mem_dout", {24'd0, mem_dout}, 32'd0);

    // Controller is back in IDLE and serves a fresh request normally
    lsb_pulse(1'b0, 32'h201, 3'b001, 32'd0, t);
    push_lsb(32'h0000_00BE, t + 3, 1'b1);
    drain("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global enable; low = freeze.
REQ-004 lsb_enable  in  1  one-cycle request pulse from load/store buffer.
REQ-005 lsb_is_write  in  1  1 = store, 0 = load.
REQ-006 lsb_addr  in  32  byte address of first byte.
REQ-007 lsb_data_len  in  3  bytes to transfer: 3'b001, 3'b010 or 3'b100.
REQ-008 lsb_write_data  in  32  store data, little-endian, low len bytes used.
REQ-009 lsb_data_valid  out  1  one-cycle completion pulse (load and store).
REQ-010 lsb_data  out  32  load result, zero-extended; unused upper bytes 0.
REQ-011 if_enable  in  1  one-cycle instruction-fetch request pulse (always 4-byte read).
REQ-012 if_addr  in  32  fetch address.
REQ-013 if_data_valid  out  1  one-cycle fetch completion pulse.
REQ-014 if_data  out  32  fetched word.
REQ-015 mem_din  in  8  RAM read byte, valid the cycle after its address.
REQ-016 mem_dout  out  8  RAM write byte.
REQ-017 mem_a  out  32  RAM byte address.
REQ-018 mem_wr  out  1  1 = write mem_dout to mem_a this cycle.
REQ-019 io_buffer_full  in  1  1 = I/O output buffer cannot accept a write.

Function
REQ-020 Each port SHALL have one pending slot capturing address/len/kind/data on its enable pulse; slot cleared when request starts; pulse on an occupied slot ignored.
REQ-021 States: IDLE, READ, WRITE; one request in flight at a time.
REQ-022 IDLE: pending LSB slot SHALL win over pending IF slot; a request captured in cycle T is startable in T+1 (enable pulse seen directly when slot empty, same-cycle start allowed).
REQ-023 READ of N bytes: byte i address driven cycle S+i (i=0..N-1, mem_wr=0), mem_din sampled cycle S+i+1 into byte lane i; data_valid pulse in cycle S+N+1; return to IDLE same edge.
REQ-024 WRITE of N bytes: byte i driven on mem_a/mem_dout with mem_wr=1 in cycle S+i; lsb_data_valid pulse in cycle S+N.
REQ-025 Write to I/O space (addr[17:16]==2'b11) while io_buffer_full=1: mem_wr=0, byte index held, retry next cycle.
REQ-026 Illegal lsb_data_len values SHALL be treated as 4 bytes.
REQ-027 Address arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
REQ-028 data_valid pulses SHALL be exactly one cycle; data outputs hold value until next completion on that port.
REQ-029 rdy=0: all state, counters, slots frozen; mem_wr forced 0; enable pulses ignored; no data_valid.
REQ-030 Outside WRITE (or during I/O stall) mem_wr SHALL be 0.

Reset
REQ-031 rst SHALL force state IDLE, both slots empty, byte counter 0, mem_wr=0, mem_a=0, mem_dout=0, lsb/if_data_valid=0, lsb_data=0, if_data=0.
REQ-032 rst mid-transfer SHALL abort the request with no completion pulse; rst has priority over rdy.

Structure
REQ-033 Shared package SHALL hold state encoding, length codes (1/2/4), I/O address-space decode constant.
REQ-034 One sub-module mem_req_slot (pending-request latch, instanced per port) is natural; FSM and datapath stay in mem_ctrl.

Verification
REQ-035 LSB LW 0x100, RAM bytes 11,22,33,44 -> lsb_data=0x44332211, valid exactly 6 cycles after pulse (S=T+1, N=4).
REQ-036 LSB SH 0x200 data 0xDEADBEEF -> mem_wr at 0x200=EF, 0x201=BE, consecutive cycles; valid after 2nd byte; 0x202 untouched.
REQ-037 lsb_enable and if_enable same cycle -> LSB served first, IF starts the cycle after LSB completion, both valid once.
REQ-038 SB to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low 3 cycles, then one write, valid next cycle.
REQ-039 rdy low 2 cycles mid-LW -> completion delayed exactly 2 cycles, same data; rst mid-LW -> no valid, IDLE, outputs 0.
